// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file write-back front end.
package regfile_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_REGBITS = 4;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } wb_src_t;

  typedef struct packed {
    logic [DEF_REGBITS-1:0] addr;
    logic [DEF_WIDTH-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Two-entry write queue; slot 0 is always the head, so a pop shifts slot 1 down.
module wb_fifo2
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output logic [1:0]      count,
  output wb_entry_t       head,
  output logic [1:0]      entry_valid,
  output wb_entry_t [1:0] entries
);

  wb_entry_t [1:0] mem;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      mem   <= '0;
    end else if (do_push && do_pop) begin
      // A pop at count 1 empties slot 0, so the new entry lands straight in the head.
      if (count == 2'd1) begin
        mem[0] <= push_entry;
      end else begin
        mem[0] <= mem[1];
        mem[1] <= push_entry;
      end
    end else if (do_pop) begin
      mem[0] <= mem[1];
      count  <= count - 2'd1;
    end else if (do_push) begin
      mem[count[0]] <= push_entry;
      count         <= count + 2'd1;
    end
  end

  assign head           = mem[0];
  assign entries        = mem;
  assign entry_valid[0] = (count != 2'd0);
  assign entry_valid[1] = (count == 2'd2);

endmodule

// File: rtl/regfile_writeback.sv
// Queues ALU and load results, round-robins them onto the register file write port,
// and publishes a per-register pending-write scoreboard.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REGBITS = DEF_REGBITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REGBITS-1:0]    a_addr,
  input  logic [WIDTH-1:0]      a_data,
  input  logic                  l_valid,
  output logic                  l_ready,
  input  logic [REGBITS-1:0]    l_addr,
  input  logic [WIDTH-1:0]      l_data,
  output logic                  regwrite,
  output logic [REGBITS-1:0]    wa,
  output logic [WIDTH-1:0]      wd,
  output logic [2**REGBITS-1:0] busy
);

  localparam int NREG = 2 ** REGBITS;

  logic [1:0]      a_count, l_count;
  logic [1:0]      a_ev, l_ev;
  wb_entry_t       a_head, l_head;
  wb_entry_t [1:0] a_entries, l_entries;
  wb_entry_t       a_entry, l_entry;
  logic            a_push, l_push;
  logic            grant_a, grant_l;
  wb_src_t         last_grant;

  assign a_ready = (a_count < 2'd2);
  assign l_ready = (l_count < 2'd2);

  // Writes to r0 complete the handshake but are never queued.
  assign a_push  = a_valid && a_ready && (a_addr != '0);
  assign l_push  = l_valid && l_ready && (l_addr != '0);
  assign a_entry = '{addr: a_addr, data: a_data};
  assign l_entry = '{addr: l_addr, data: l_data};

  wb_fifo2 u_alu_q (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (a_push),
    .push_entry  (a_entry),
    .pop         (grant_a),
    .count       (a_count),
    .head        (a_head),
    .entry_valid (a_ev),
    .entries     (a_entries)
  );

  wb_fifo2 u_load_q (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (l_push),
    .push_entry  (l_entry),
    .pop         (grant_l),
    .count       (l_count),
    .head        (l_head),
    .entry_valid (l_ev),
    .entries     (l_entries)
  );

  always_comb begin
    grant_a = a_ev[0] && (!l_ev[0] || (last_grant == SRC_LOAD));
    grant_l = l_ev[0] && !grant_a;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regwrite   <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      last_grant <= SRC_LOAD;
    end else if (grant_a) begin
      regwrite   <= 1'b1;
      wa         <= a_head.addr;
      wd         <= a_head.data;
      last_grant <= SRC_ALU;
    end else if (grant_l) begin
      regwrite   <= 1'b1;
      wa         <= l_head.addr;
      wd         <= l_head.data;
      last_grant <= SRC_LOAD;
    end else begin
      regwrite <= 1'b0;
    end
  end

  // Built only from queue contents and the output registers, never from *_valid.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (a_ev[i] && (a_entries[i].addr == REGBITS'(r))) busy[r] = 1'b1;
        if (l_ev[i] && (l_entries[i].addr == REGBITS'(r))) busy[r] = 1'b1;
      end
      if (regwrite && (wa == REGBITS'(r))) busy[r] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: vector table, port-order scoreboard, corner sequences.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, l_valid;
  logic        a_ready, l_ready;
  logic [3:0]  a_addr, l_addr;
  logic [15:0] a_data, l_data;
  logic        regwrite;
  logic [3:0]  wa;
  logic [15:0] wd;
  logic [15:0] busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        is_load;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        exp_rw;
    logic [3:0]  exp_wa;
    logic [15:0] exp_wd;
    logic [15:0] exp_busy;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  regfile_writeback #(.WIDTH(16), .REGBITS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .l_valid  (l_valid),
    .l_ready  (l_ready),
    .l_addr   (l_addr),
    .l_data   (l_data),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                               input logic lv, input logic [3:0] la, input logic [15:0] ld);
    a_valid = av;
    a_addr  = aa;
    a_data  = ad;
    l_valid = lv;
    l_addr  = la;
    l_data  = ld;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
  endtask

  task automatic expectWrite(input logic [3:0] addr, input logic [15:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    for (int k = 0; k < budget && sb.size() > 0; k++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Port monitor: every write on the register file port must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && regwrite) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: got wa=%0d wd=0x%0h expected no write", wa, wd);
      end else begin
        e = sb.pop_front();
        checkOutput("port_wa", 32'(wa), 32'(e.addr));
        checkOutput("port_wd", 32'(wd), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit [4:1] exp_ar;
    bit [4:1] exp_lr;
    int       ai;
    int       li;
    logic     hs_a;
    logic     hs_l;

    vecs[0] = '{1'b0, 4'd5,  16'h1234, 1'b1, 4'd5,  16'h1234, 16'h0020};
    vecs[1] = '{1'b0, 4'd0,  16'hFFFF, 1'b0, 4'd5,  16'h1234, 16'h0000};
    vecs[2] = '{1'b1, 4'd7,  16'hBEEF, 1'b1, 4'd7,  16'hBEEF, 16'h0080};
    vecs[3] = '{1'b1, 4'd0,  16'h5555, 1'b0, 4'd7,  16'hBEEF, 16'h0000};
    vecs[4] = '{1'b0, 4'd15, 16'hA5A5, 1'b1, 4'd15, 16'hA5A5, 16'h8000};
    vecs[5] = '{1'b1, 4'd1,  16'h0001, 1'b1, 4'd1,  16'h0001, 16'h0002};

    idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_regwrite", 32'(regwrite), 32'd0);
    checkOutput("rst_wa", 32'(wa), 32'd0);
    checkOutput("rst_wd", 32'(wd), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_a_ready", 32'(a_ready), 32'd1);
    checkOutput("rst_l_ready", 32'(l_ready), 32'd1);
    reset_n = 1'b1;

    // Single writes from one source at a time, exact cycle timing.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vecs[i].is_load) applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, vecs[i].addr, vecs[i].data);
      else                 applyStimulus(1'b1, vecs[i].addr, vecs[i].data, 1'b0, 4'd0, 16'h0);
      if (vecs[i].exp_rw) expectWrite(vecs[i].addr, vecs[i].data);
      @(negedge clk);
      idle();
      checkOutput($sformatf("vec%0d_c1_regwrite", i), 32'(regwrite), 32'd0);
      checkOutput($sformatf("vec%0d_c1_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_c2_regwrite", i), 32'(regwrite), 32'(vecs[i].exp_rw));
      checkOutput($sformatf("vec%0d_c2_wa", i), 32'(wa), 32'(vecs[i].exp_wa));
      checkOutput($sformatf("vec%0d_c2_wd", i), 32'(wd), 32'(vecs[i].exp_wd));
      checkOutput($sformatf("vec%0d_c2_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_c3_regwrite", i), 32'(regwrite), 32'd0);
      checkOutput($sformatf("vec%0d_c3_busy", i), 32'(busy), 32'd0);
    end

    // Both sources streaming: grants alternate and readies toggle.
    doReset();
    expectWrite(4'd1, 16'h0101);
    expectWrite(4'd9, 16'h0909);
    expectWrite(4'd2, 16'h0202);
    expectWrite(4'd10, 16'h0A0A);
    expectWrite(4'd3, 16'h0303);
    expectWrite(4'd11, 16'h0B0B);
    exp_ar = 4'b1011;
    exp_lr = 4'b0101;
    ai = 0;
    li = 0;
    @(negedge clk);
    applyStimulus(1'b1, 4'd1, 16'h0101, 1'b1, 4'd9, 16'h0909);
    hs_a = a_valid && a_ready;
    hs_l = l_valid && l_ready;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (hs_a) ai++;
      if (hs_l) li++;
      if (c <= 4) begin
        checkOutput($sformatf("rr_c%0d_a_ready", c), 32'(a_ready), 32'(exp_ar[c]));
        checkOutput($sformatf("rr_c%0d_l_ready", c), 32'(l_ready), 32'(exp_lr[c]));
      end
      applyStimulus(ai < 3, 4'(ai + 1), 16'(32'h0101 * (ai + 1)),
                    li < 3, 4'(li + 9), 16'(32'h0909 + 32'h0101 * li));
      hs_a = a_valid && a_ready;
      hs_l = l_valid && l_ready;
    end
    idle();
    waitDrain(20);

    // Load-only stream: one write per cycle with l_ready held high.
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'h4000);
    for (int k = 0; k < 4; k++) expectWrite(4'(k + 4), 16'(32'h4000 + k));
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("ld_c%0d_regwrite", c), 32'(regwrite), 32'((c >= 2) && (c <= 5)));
      if (c <= 4) checkOutput($sformatf("ld_c%0d_l_ready", c), 32'(l_ready), 32'd1);
      if (c < 4) applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'(c + 4), 16'(32'h4000 + c));
      else       idle();
    end
    waitDrain(10);

    // Back-to-back writes to r3 keep busy[3] high without a gap.
    @(negedge clk);
    applyStimulus(1'b1, 4'd3, 16'h0001, 1'b0, 4'd0, 16'h0);
    expectWrite(4'd3, 16'h0001);
    expectWrite(4'd3, 16'h0002);
    @(negedge clk);
    applyStimulus(1'b1, 4'd3, 16'h0002, 1'b0, 4'd0, 16'h0);
    checkOutput("b2b_c1_busy", 32'(busy), 32'h0008);
    checkOutput("b2b_c1_regwrite", 32'(regwrite), 32'd0);
    @(negedge clk);
    idle();
    checkOutput("b2b_c2_busy", 32'(busy), 32'h0008);
    checkOutput("b2b_c2_wd", 32'(wd), 32'h0001);
    @(negedge clk);
    checkOutput("b2b_c3_busy", 32'(busy), 32'h0008);
    checkOutput("b2b_c3_wd", 32'(wd), 32'h0002);
    @(negedge clk);
    checkOutput("b2b_c4_busy", 32'(busy), 32'd0);
    checkOutput("b2b_c4_regwrite", 32'(regwrite), 32'd0);

    // Asynchronous reset with both queues loaded discards everything in flight.
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 4'd12, 16'h0C0C, 1'b1, 4'd14, 16'h0E0E);
    expectWrite(4'd12, 16'h0C0C);
    @(negedge clk);
    applyStimulus(1'b1, 4'd13, 16'h0D0D, 1'b1, 4'd15, 16'h0F0F);
    @(negedge clk);
    idle();
    checkOutput("rst2_pre_regwrite", 32'(regwrite), 32'd1);
    checkOutput("rst2_pre_busy", 32'(busy), 32'hF000);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst2_async_regwrite", 32'(regwrite), 32'd0);
    checkOutput("rst2_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    #1;
    checkOutput("rst2_post_busy", 32'(busy), 32'd0);
    checkOutput("rst2_post_a_ready", 32'(a_ready), 32'd1);
    checkOutput("rst2_post_l_ready", 32'(l_ready), 32'd1);
    checkOutput("rst2_post_wa", 32'(wa), 32'd0);
    checkOutput("rst2_post_wd", 32'(wd), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("rst2_no_stale_busy", 32'(busy), 32'd0);
    waitDrain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the three-ported register file: accepts result writes from the ALU and the load unit, buffers each in its own 2-entry queue, and drives the register file write port (`regwrite`, `wa`, `wd`) with at most one write per cycle. Arbitration between the two sources is round-robin. A per-register pending-write scoreboard (`busy`) tells the issue stage which registers still have writes in flight. Writes to register 0 are discarded so r0 reads as zero.

## Interface
- `WIDTH`, 16, data width; matches the register file.
- `REGBITS`, 4, register address width; the block tracks 2^REGBITS registers.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  ALU result valid.
- `a_ready`  out  1  ALU queue can accept.
- `a_addr`  in  REGBITS  ALU destination register.
- `a_data`  in  WIDTH  ALU result.
- `l_valid`  in  1  load result valid.
- `l_ready`  out  1  load queue can accept.
- `l_addr`  in  REGBITS  load destination register.
- `l_data`  in  WIDTH  load data.
- `regwrite`  out  1  register file write enable (registered).
- `wa`  out  REGBITS  register file write address (registered).
- `wd`  out  WIDTH  register file write data (registered).
- `busy`  out  2^REGBITS  bit r is high while any write to register r is queued or on the write port.

## Operation
- Handshake: a source transfer happens on a rising edge when `x_valid && x_ready`.
- `x_ready` depends only on the source's queue count: it is high when count < 2. There is no same-cycle bypass, so a full queue rejects a push even in a cycle where it pops.
- A transfer with addr == 0 is accepted (ready behaves normally) but is dropped: it is not enqueued and never produces `regwrite`.
- Each queue is a FIFO, so writes from one source reach the port in acceptance order.
- Arbiter, each cycle:
  - If exactly one queue is non-empty, that queue's head is granted.
  - If both queues are non-empty, the source not granted last time wins.
  - The `last_grant` register resets to LOAD, so the ALU wins the first tie.
- The granted head is popped and loaded into the output registers: `regwrite` = 1, `wa` = addr, `wd` = data.
  - With no grant, `regwrite` = 0 and `wa`/`wd` hold their previous values.
- Ordering between sources is not enforced. The issue stage must use `busy` to avoid issuing a second writer to a busy register.
- `busy[r]` = OR over both queues' valid entries with addr == r, OR (`regwrite` && `wa` == r). `busy[0]` is always 0.
  - `busy` is combinational from registered state only, with no path from the `*_valid` inputs.
- Reset values: `a_ready` = `l_ready` = 1, `regwrite` = 0, `wa` = 0, `wd` = 0, `busy` = 0, both queues empty, `last_grant` = LOAD.

## Timing
- Transfer accepted at edge E0 → entry in queue during cycle C1.
- Granted in C1 if uncontended → `regwrite` high in C2 → register file captures at the end of C2.
- Minimum latency: 2 cycles from handshake to `regwrite`. Throughput: 1 write per cycle sustained.
- `busy[r]` rises in the cycle after acceptance and falls in the cycle after the `regwrite` cycle, unless another write to r is still pending.
- Simultaneous push and pop on one queue at count 1 leaves the count at 1.
- Both sources pushing while both queues are non-empty:
  - Grants alternate ALU/LOAD every cycle.
  - Each queue drains at 1 entry per 2 cycles, so `x_ready` toggles.
- Assertion of `reset_n` mid-operation clears queued writes immediately and asynchronously. `regwrite` drops without waiting for a clock edge, and the pending writes are lost.

## Structure
- Package `regfile_pkg`:
  - default `WIDTH`/`REGBITS` constants;
  - `wb_src_t` enum {`SRC_ALU`, `SRC_LOAD`};
  - `wb_entry_t` struct {addr, data}.
- Sub-module `wb_fifo2`: a 2-entry queue of `wb_entry_t` with push, pop, count, head, and per-entry valid outputs. It is instantiated twice, and the scoreboard reads its entry valid outputs.
- Arbiter, output registers, and scoreboard live in the top module.

## Test plan
- Reset, then a single ALU write (addr 5, data 0x1234) → `regwrite` = 1, `wa` = 5, `wd` = 0x1234 exactly 2 cycles after the handshake; `busy[5]` high for those 2 cycles plus the regwrite cycle, then low.
- Write to addr 0 with data 0xFFFF → accepted, no `regwrite` ever, `busy` stays 0.
- Both sources valid every cycle, ALU addrs 1, 2, 3 and load addrs 9, 10, 11 → port order 1, 9, 2, 10, 3, 11; `a_ready`/`l_ready` deassert when the respective count reaches 2.
- Load valid held with no ALU traffic, 4 writes to addrs 4..7 → 4 consecutive `regwrite` cycles; `l_ready` stays 1.
- Fill both queues, then pull `reset_n` low for 1 cycle → `regwrite` = 0 immediately; `busy` = 0 and both readies = 1 after release; no stale write appears afterwards.
- Two ALU writes to addr 3 back-to-back (0x0001, then 0x0002) → two `regwrite` cycles in order; `busy[3]` stays high continuously until the cycle after the second write.
